mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one external memory bus between the pipeline's instruction-fetch port and data port.
- Replaces the two ideal single-cycle memories. Fetch PC/instruction and ALU-out/write-data/read-data connect here.
- Per-port stall outputs go to the hazard unit, which ORs them into its stallF/stallD/flush decisions.
- Bus handshake is req/ack with variable slave latency. Data port has priority over fetch.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TO_CYCLES, 255, wait-cycle limit before abort; used only with MEM_TIMEOUT_EN; must be ≥1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-low
- i_req  in  1  fetch request; held stable by pipeline while i_stall=1
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetched word; valid in I_RESP cycle
- i_stall  out  1  fetch not yet served
- d_req  in  1  data request; held stable while d_stall=1
- d_wen  in  4  byte write enables; 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid in D_RESP cycle
- d_stall  out  1  data access not yet served
- m_req  out  1  bus request
- m_wen  out  4  bus byte enables
- m_addr  out  AW  bus address
- m_wdata  out  DW  bus write data
- m_rdata  in  DW  bus read data; valid when m_ack=1
- m_ack  in  1  bus completion strobe, single cycle
- err  out  1  sticky bus-timeout flag

Behaviour:
- States: IDLE, I_BUSY, D_BUSY, I_RESP, D_RESP. Reset state is IDLE.
- Reset (rst=0, async):
  - state=IDLE.
  - m_req, m_wen, m_addr, m_wdata, i_rdata, d_rdata, err all 0.
  - Any in-flight transaction is abandoned immediately; m_req drops without waiting for clk.
- IDLE:
  - d_req=1: latch d_addr/d_wen/d_wdata into the m_* registers, m_req<=1, go to D_BUSY.
  - Else i_req=1: latch i_addr, m_wen<=0, m_req<=1, go to I_BUSY.
  - Else stay in IDLE.
- x_BUSY:
  - m_ack=1 sampled: capture m_rdata into x_rdata (d_rdata also captured on writes), m_req<=0, m_wen<=0, go to x_RESP.
  - m_ack=0: hold all m_* outputs stable.
- x_RESP: one cycle, then IDLE. x_rdata holds its value until that port's next completion.
- Stall outputs are combinational:
  - i_stall = i_req & (state != I_RESP)
  - d_stall = d_req & (state != D_RESP)
  - During reset, stalls therefore equal their requests.
- Latency: request seen in IDLE at cycle 0, m_req high from cycle 1. With ack at cycle N≥1, RESP is cycle N+1. Minimum stall is 2 cycles.
- Simultaneous i_req & d_req in IDLE:
  - Data served first; i_stall stays 1 throughout.
  - Fetch is granted in the IDLE cycle following D_RESP.
  - No starvation: the pipeline cannot issue a new d_req while fetch is stalled.
- Request withdrawn (flush) after grant: the transaction completes normally and RESP still occurs. The requester ignores the returned data.
- Request withdrawn while still in IDLE: nothing is issued.
- m_ack outside x_BUSY is ignored.
- Back-to-back requests from the same port: one IDLE cycle between RESP and the next grant.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to x_BUSY and increments on each cycle with m_ack=0.
  - When the count reaches TO_CYCLES: m_req<=0, x_rdata<=32'hDEADBEEF, err<=1 (sticky until reset), go to x_RESP.
  - An ack arriving in the same cycle as the limit wins: normal completion, err unchanged.
- Undefined: no counter; x_BUSY waits indefinitely; err is tied to 0.

Test Plan:
- Fetch with zero-wait ack: i_req=1, i_addr=0x00000040, slave acks in cycle 1 with m_rdata=0x8C020004.
  - Required: m_addr=0x40 and m_wen=0 in cycle 1.
  - Required: i_stall=1 in cycles 0–1, 0 in cycle 2; i_rdata=0x8C020004 in cycle 2.
- Store with 3-cycle wait: d_req=1, d_wen=4'hF, d_addr=0x100, d_wdata=0x12345678, ack at cycle 4.
  - Required: m_req high in cycles 1–4 with stable addr/data; d_stall falls in cycle 5; m_wen=0 after.
- Collision: i_req and d_req both asserted in cycle 0, each ack after 1 cycle.
  - Required: data bus cycle first; D_RESP at cycle 2; fetch granted at cycle 3; I_RESP at cycle 5.
  - Required: i_stall=1 throughout cycles 0–4.
- Flush after grant: d_req drops in cycle 2 while in D_BUSY, ack at cycle 3.
  - Required: D_RESP at cycle 4, then IDLE; no new bus request issued.
- Reset mid-transaction: rst=0 during I_BUSY.
  - Required: m_req=0 immediately, without waiting for a clk edge; all outputs 0.
  - Required: after release with i_req=1, a fresh grant occurs.
- With MEM_TIMEOUT_EN and TO_CYCLES=4, slave never acks.
  - Required: m_req drops after 4 wait cycles; i_rdata=0xDEADBEEF; err=1 and stays 1.
  - Without the macro: i_stall stays 1 and err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single req/ack memory bus; data port has priority.
// Optional bus timeout with sticky err is enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_stall,
    input  logic          d_req,
    input  logic [3:0]    d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          m_req,
    output logic [3:0]    m_wen,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          err,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_BUSY = 3'd1,
        D_BUSY = 3'd2,
        I_RESP = 3'd3,
        D_RESP = 3'd4
    } state_t;

    state_t state;

`ifdef MEM_TIMEOUT_EN
    localparam int            CW      = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);
    localparam logic [DW-1:0] TO_DATA = DW'(32'hDEADBEEF);
    logic [CW-1:0] wait_cnt;
`else
    assign err = 1'b0;
`endif

    // Handshake: a bus transfer is open while m_req=1; it closes on the single-cycle m_ack.
    // m_* outputs are held constant for the whole open interval.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            m_req   <= 1'b0;
            m_wen   <= 4'd0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
`ifdef MEM_TIMEOUT_EN
            err      <= 1'b0;
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (d_req) begin
                        m_addr  <= d_addr;
                        m_wen   <= d_wen;
                        m_wdata <= d_wdata;
                        m_req   <= 1'b1;
                        state   <= D_BUSY;
                    end else if (i_req) begin
                        m_addr <= i_addr;
                        m_wen  <= 4'd0;
                        m_req  <= 1'b1;
                        state  <= I_BUSY;
                    end
`ifdef MEM_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                I_BUSY, D_BUSY: begin
                    if (m_ack) begin
                        // Writes also capture m_rdata into d_rdata
                        if (state == I_BUSY) i_rdata <= m_rdata;
                        else                 d_rdata <= m_rdata;
                        m_req <= 1'b0;
                        m_wen <= 4'd0;
                        state <= (state == I_BUSY) ? I_RESP : D_RESP;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        if (state == I_BUSY) i_rdata <= TO_DATA;
                        else                 d_rdata <= TO_DATA;
                        m_req <= 1'b0;
                        m_wen <= 4'd0;
                        err   <= 1'b1;
                        state <= (state == I_BUSY) ? I_RESP : D_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                I_RESP, D_RESP: state <= IDLE;
                default:        state <= IDLE;
            endcase
        end
    end

    assign i_stall   = i_req & (state != I_RESP);
    assign d_stall   = d_req & (state != D_RESP);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: bus-start and response scoreboards plus per-cycle checks.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [2:0] S_IDLE = 3'd0, S_IBUSY = 3'd1, S_DBUSY = 3'd2,
                         S_IRESP = 3'd3, S_DRESP = 3'd4;

  logic clk, rst;
  logic i_req, i_stall, d_req, d_stall, m_req, m_ack, err;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;
  logic [3:0] d_wen, m_wen;
  logic [2:0] dbg_state;

  logic [67:0] exp_bus_q[$];   // {wen, addr, wdata}
  logic [32:0] exp_resp_q[$];  // {is_data, rdata}
  int n_cmp = 0;
  int n_fail = 0;
  logic prev_req = 1'b0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TO_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_bus(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
    exp_bus_q.push_back({w, a, wd});
  endtask

  task automatic push_resp(input logic is_d, input logic [31:0] rd);
    exp_resp_q.push_back({is_d, rd});
  endtask

  // monitor: bus transfer starts and port responses
  always @(negedge clk) begin
    logic [67:0] eb;
    logic [32:0] er;
    logic is_d;
    if (rst) begin
      if (m_req && !prev_req) begin
        if (exp_bus_q.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
        else begin
          eb = exp_bus_q.pop_front();
          chk("bus_wen", {28'd0, m_wen}, {28'd0, eb[67:64]});
          chk("bus_addr", m_addr, eb[63:32]);
          if (eb[67:64] != 4'd0) chk("bus_wdata", m_wdata, eb[31:0]);
        end
      end
      if (dbg_state == S_IRESP || dbg_state == S_DRESP) begin
        is_d = (dbg_state == S_DRESP);
        if (exp_resp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
        else begin
          er = exp_resp_q.pop_front();
          chk("resp_port", {31'd0, is_d}, {31'd0, er[32]});
          chk("resp_data", is_d ? d_rdata : i_rdata, er[31:0]);
        end
      end
    end
    prev_req = m_req;
  end

  initial begin
    rst = 1'b0; i_req = 1'b1; i_addr = '0; d_req = 1'b0; d_wen = 4'd0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack = 1'b0;

    // reset state
    sample();
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    chk("rst_i_stall", {31'd0, i_stall}, 32'd1);
    chk("rst_d_stall", {31'd0, d_stall}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    i_req = 1'b0;
    step(); rst = 1'b1;
    step();

    // fetch, zero-wait ack
    step(); i_req = 1'b1; i_addr = 32'h40;
    push_bus(4'd0, 32'h40, 32'd0); push_resp(1'b0, 32'h8C020004);
    sample(); chk("t1_c0_stall", {31'd0, i_stall}, 32'd1); chk("t1_c0_mreq", {31'd0, m_req}, 32'd0);
    step(); m_ack = 1'b1; m_rdata = 32'h8C020004;
    sample();
    chk("t1_c1_mreq", {31'd0, m_req}, 32'd1); chk("t1_c1_addr", m_addr, 32'h40);
    chk("t1_c1_wen", {28'd0, m_wen}, 32'd0); chk("t1_c1_stall", {31'd0, i_stall}, 32'd1);
    step(); m_ack = 1'b0; m_rdata = 32'h0;
    sample(); chk("t1_c2_stall", {31'd0, i_stall}, 32'd0); chk("t1_c2_rdata", i_rdata, 32'h8C020004);
    step(); i_req = 1'b0;
    step(); sample(); chk("t1_no_regrant", {31'd0, m_req}, 32'd0);

    // store, 3 wait cycles
    step(); d_req = 1'b1; d_wen = 4'hF; d_addr = 32'h100; d_wdata = 32'h12345678;
    push_bus(4'hF, 32'h100, 32'h12345678); push_resp(1'b1, 32'hA5A5A5A5);
    sample();
    for (int c = 1; c <= 4; c++) begin
      step(); m_ack = (c == 4); m_rdata = (c == 4) ? 32'hA5A5A5A5 : 32'h0;
      sample();
      chk("t2_mreq", {31'd0, m_req}, 32'd1); chk("t2_addr", m_addr, 32'h100);
      chk("t2_wdata", m_wdata, 32'h12345678); chk("t2_stall", {31'd0, d_stall}, 32'd1);
    end
    step(); m_ack = 1'b0; m_rdata = 32'h0;
    sample();
    chk("t2_c5_stall", {31'd0, d_stall}, 32'd0); chk("t2_c5_wen", {28'd0, m_wen}, 32'd0);
    chk("t2_c5_mreq", {31'd0, m_req}, 32'd0); chk("t2_c5_rdata", d_rdata, 32'hA5A5A5A5);
    step(); d_req = 1'b0; d_wen = 4'd0;
    step();

    // collision: data first, then fetch
    step(); i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_addr = 32'h200;
    push_bus(4'd0, 32'h200, 32'd0); push_bus(4'd0, 32'h44, 32'd0);
    push_resp(1'b1, 32'h11112222); push_resp(1'b0, 32'h33334444);
    sample(); chk("t3_c0_istall", {31'd0, i_stall}, 32'd1);
    step(); m_ack = 1'b1; m_rdata = 32'h11112222;
    sample(); chk("t3_c1_state", {29'd0, dbg_state}, {29'd0, S_DBUSY}); chk("t3_c1_istall", {31'd0, i_stall}, 32'd1);
    step(); m_ack = 1'b0;
    sample(); chk("t3_c2_state", {29'd0, dbg_state}, {29'd0, S_DRESP});
    chk("t3_c2_dstall", {31'd0, d_stall}, 32'd0); chk("t3_c2_istall", {31'd0, i_stall}, 32'd1);
    step(); d_req = 1'b0;
    sample(); chk("t3_c3_state", {29'd0, dbg_state}, {29'd0, S_IDLE}); chk("t3_c3_istall", {31'd0, i_stall}, 32'd1);
    step(); m_ack = 1'b1; m_rdata = 32'h33334444;
    sample(); chk("t3_c4_state", {29'd0, dbg_state}, {29'd0, S_IBUSY});
    chk("t3_c4_addr", m_addr, 32'h44); chk("t3_c4_istall", {31'd0, i_stall}, 32'd1);
    step(); m_ack = 1'b0;
    sample(); chk("t3_c5_state", {29'd0, dbg_state}, {29'd0, S_IRESP}); chk("t3_c5_istall", {31'd0, i_stall}, 32'd0);
    step(); i_req = 1'b0;
    step();

    // flush after grant, stray ack in IDLE
    step(); d_req = 1'b1; d_addr = 32'h300;
    push_bus(4'd0, 32'h300, 32'd0); push_resp(1'b1, 32'h55556666);
    sample();
    step(); sample(); chk("t4_c1_state", {29'd0, dbg_state}, {29'd0, S_DBUSY});
    step(); d_req = 1'b0;
    step(); m_ack = 1'b1; m_rdata = 32'h55556666;
    step(); m_ack = 1'b0;
    sample(); chk("t4_c4_state", {29'd0, dbg_state}, {29'd0, S_DRESP}); chk("t4_c4_mreq", {31'd0, m_req}, 32'd0);
    step(); m_ack = 1'b1; m_rdata = 32'hBAD0BAD0;
    sample(); chk("t4_c5_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    step(); m_ack = 1'b0;
    sample(); chk("t4_c6_mreq", {31'd0, m_req}, 32'd0); chk("t4_c6_rdata", d_rdata, 32'h55556666);
    chk("t4_c6_state", {29'd0, dbg_state}, {29'd0, S_IDLE});

    // asynchronous reset mid-transaction
    step(); i_req = 1'b1; i_addr = 32'h80;
    push_bus(4'd0, 32'h80, 32'd0);
    step(); sample(); chk("t5_busy_mreq", {31'd0, m_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_mreq", {31'd0, m_req}, 32'd0); chk("t5_async_addr", m_addr, 32'd0);
    chk("t5_async_irdata", i_rdata, 32'd0); chk("t5_async_drdata", d_rdata, 32'd0);
    chk("t5_async_state", {29'd0, dbg_state}, {29'd0, S_IDLE}); chk("t5_async_istall", {31'd0, i_stall}, 32'd1);
    step(); rst = 1'b1;
    push_bus(4'd0, 32'h80, 32'd0); push_resp(1'b0, 32'h77778888);
    sample(); chk("t5_rel_mreq", {31'd0, m_req}, 32'd0);
    step(); m_ack = 1'b1; m_rdata = 32'h77778888;
    sample(); chk("t5_regrant_mreq", {31'd0, m_req}, 32'd1);
    step(); m_ack = 1'b0;
    sample(); chk("t5_rdata", i_rdata, 32'h77778888);
    step(); i_req = 1'b0;
    step();

    // slave never acks
    step(); i_req = 1'b1; i_addr = 32'hC0;
    push_bus(4'd0, 32'hC0, 32'd0);
`ifdef MEM_TIMEOUT_EN
    push_resp(1'b0, 32'hDEADBEEF);
    sample();
    for (int c = 1; c <= 4; c++) begin
      step(); sample();
      chk("t6_wait_mreq", {31'd0, m_req}, 32'd1); chk("t6_wait_err", {31'd0, err}, 32'd0);
    end
    step(); sample();
    chk("t6_to_mreq", {31'd0, m_req}, 32'd0); chk("t6_to_rdata", i_rdata, 32'hDEADBEEF);
    chk("t6_to_err", {31'd0, err}, 32'd1); chk("t6_to_stall", {31'd0, i_stall}, 32'd0);
    step(); i_req = 1'b0;
    repeat (3) step();
    sample(); chk("t6_err_sticky", {31'd0, err}, 32'd1);
`else
    sample();
    repeat (10) step();
    sample();
    chk("t6_hang_stall", {31'd0, i_stall}, 32'd1); chk("t6_hang_err", {31'd0, err}, 32'd0);
    chk("t6_hang_mreq", {31'd0, m_req}, 32'd1);
    step(); m_ack = 1'b1; m_rdata = 32'h9999AAAA;
    push_resp(1'b0, 32'h9999AAAA);
    step(); m_ack = 1'b0;
    sample(); chk("t6_late_rdata", i_rdata, 32'h9999AAAA);
    step(); i_req = 1'b0;
`endif

    repeat (2) step();
    sample();
    chk("bus_q_empty", exp_bus_q.size(), 32'd0);
    chk("resp_q_empty", exp_resp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
